// File: rtl/uart_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder_pkg
// Description : Shared definitions for the UART command decoder.
//               - Link FSM state encoding (LINK_DOWN / LINK_UP / FAULT)
//               - SECDED decode status codes (CLEAN / CORR / DOUBLE)
//               - Frame bit positions and the data-extraction helper
//               - Default parameter values (timeout, bad-frame limit, safe cmd)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_decoder_pkg;

    typedef enum logic [1:0] {
        LINK_DOWN = 2'd0,
        LINK_UP   = 2'd1,
        FAULT     = 2'd2
    } link_state_e;

    typedef enum logic [1:0] {
        SEC_CLEAN  = 2'd0,
        SEC_CORR   = 2'd1,
        SEC_DOUBLE = 2'd2
    } secded_status_e;

    // Frame layout: bits[6:0] are Hamming positions 1..7, bit 7 is overall parity.
    localparam int unsigned POS_D0  = 2;
    localparam int unsigned POS_D1  = 4;
    localparam int unsigned POS_D2  = 5;
    localparam int unsigned POS_D3  = 6;
    localparam int unsigned POS_PAR = 7;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 288;
    localparam int unsigned DEF_MAX_BAD        = 3;
    localparam logic [3:0]  DEF_SAFE_CMD       = 4'h0;

    function automatic logic [3:0] extract_data(input logic [7:0] frame);
        return {frame[POS_D3], frame[POS_D2], frame[POS_D1], frame[POS_D0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder_if
// Description : Byte handshake from the UART receiver to the command decoder.
//               rx_data    : received byte
//               rx_done    : 1-cycle strobe, rx_data valid
//               rx_par_err : UART parity error, qualified with rx_done
//               master = UART receiver side, slave = decoder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_par_err;

    modport master (output rx_data, output rx_done, output rx_par_err);
    modport slave  (input  rx_data, input  rx_done, input  rx_par_err);
endinterface
`default_nettype wire

// File: rtl/uart_cmd_decoder_secded84_dec.sv
`default_nettype none
// ============================================================================
// Module      : secded84_dec
// Description : Combinational SECDED(8,4) decoder. Computes the Hamming
//               syndrome and overall parity, corrects a single flipped bit
//               and reports CLEAN / CORR / DOUBLE.
//   frame_i  in  8  received frame
//   data_o   out 4  decoded (corrected) data nibble
//   status_o out 2  decode status
// Revision    : 1.0 - initial release
// ============================================================================
module secded84_dec
    import uart_cmd_decoder_pkg::*;
(
    input  logic [7:0]     frame_i,
    output logic [3:0]     data_o,
    output secded_status_e status_o
);

    logic [2:0] syn;
    logic       par;
    logic [7:0] fixed;

    always_comb begin
        syn[0] = frame_i[0] ^ frame_i[2] ^ frame_i[4] ^ frame_i[6];
        syn[1] = frame_i[1] ^ frame_i[2] ^ frame_i[5] ^ frame_i[6];
        syn[2] = frame_i[3] ^ frame_i[4] ^ frame_i[5] ^ frame_i[6];
        par    = ^frame_i;
        fixed    = frame_i;
        status_o = SEC_CLEAN;
        if (syn != 3'd0 && par) begin
            // Syndrome names Hamming position syn, which is frame bit syn-1.
            fixed[syn - 3'd1] = ~frame_i[syn - 3'd1];
            status_o          = SEC_CORR;
        end else if (syn == 3'd0 && par) begin
            // Only the overall parity bit flipped; data bits are intact.
            status_o = SEC_CORR;
        end else if (syn != 3'd0 && !par) begin
            status_o = SEC_DOUBLE;
        end
        data_o = extract_data(fixed);
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder
// Description : Decodes SECDED(8,4) command frames from a UART link into a
//               4-bit switch command, with link watchdog and bad-frame
//               supervisor forcing SAFE_CMD when the link is lost/faulty.
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   rx           slave   byte handshake (rx_data / rx_done / rx_par_err)
//   fault_clr_i  in   1  pulse: leave FAULT
//   cmd_out_o    out  4  current command
//   cmd_valid_o  out  1  pulse: cmd_out updated from a good frame
//   link_ok_o    out  1  high in LINK_UP
//   fault_o      out  1  high in FAULT
//   corr_cnt_o   out 16  corrected-frame count (CMD_DEC_STATS_EN)
//   drop_cnt_o   out 16  dropped-frame count   (CMD_DEC_STATS_EN)
// Build option: define CMD_DEC_STATS_EN to enable the frame counters;
//               otherwise both counters read 16'h0000.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_BAD        = DEF_MAX_BAD,
    parameter logic [3:0]  SAFE_CMD       = DEF_SAFE_CMD
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_cmd_decoder_if.slave   rx,
    input  logic                fault_clr_i,
    output logic [3:0]          cmd_out_o,
    output logic                cmd_valid_o,
    output logic                link_ok_o,
    output logic                fault_o,
    output logic [15:0]         corr_cnt_o,
    output logic [15:0]         drop_cnt_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    // Stage 1: frame capture
    logic [7:0] s1_data_q;
    logic       s1_valid_q;
    logic       s1_par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q  <= 8'h00;
            s1_valid_q <= 1'b0;
            s1_par_q   <= 1'b0;
        end else begin
            s1_valid_q <= rx.rx_done;
            if (rx.rx_done) begin
                s1_data_q <= rx.rx_data;
                s1_par_q  <= rx.rx_par_err;
            end
        end
    end

    // Stage 2: decode and supervise
    logic [3:0]     dec_data;
    secded_status_e dec_status;

    secded84_dec u_dec (
        .frame_i  (s1_data_q),
        .data_o   (dec_data),
        .status_o (dec_status)
    );

    logic good_frame;
    logic bad_frame;
    logic timeout;
    logic [3:0] bad_inc;

    // A UART parity error makes the frame bad regardless of its contents.
    assign good_frame = s1_valid_q && !s1_par_q && (dec_status != SEC_DOUBLE);
    assign bad_frame  = s1_valid_q && (s1_par_q || (dec_status == SEC_DOUBLE));

    link_state_e    state_q, state_d;
    logic [3:0]     cmd_q, cmd_d;
    logic           valid_q, valid_d;
    logic [3:0]     bad_q, bad_d;
    logic [WD_W-1:0] wd_q, wd_d;

    assign bad_inc = (bad_q == 4'hF) ? 4'hF : bad_q + 4'd1;
    assign timeout = (state_q == LINK_UP) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LINK_DOWN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= SAFE_CMD;
            valid_q <= 1'b0;
            bad_q   <= 4'd0;
            wd_q    <= '0;
        end else begin
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
            bad_q   <= bad_d;
            wd_q    <= wd_d;
        end
    end

    // Priority: fault clear > good frame > MAX_BAD > timeout.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        valid_d = 1'b0;
        bad_d   = bad_q;
        wd_d    = (state_q == LINK_UP) ? wd_q + WD_W'(1) : '0;
        if (state_q == FAULT && fault_clr_i) begin
            state_d = LINK_DOWN;
            cmd_d   = SAFE_CMD;
            wd_d    = '0;
            bad_d   = bad_frame ? 4'd1 : 4'd0;
        end else if (good_frame) begin
            bad_d = 4'd0;
            wd_d  = '0;
            // In FAULT a good frame is decoded but never reaches the switch.
            if (state_q != FAULT) begin
                state_d = LINK_UP;
                cmd_d   = dec_data;
                valid_d = 1'b1;
            end
        end else if (bad_frame && (bad_inc >= 4'(MAX_BAD))) begin
            state_d = FAULT;
            cmd_d   = SAFE_CMD;
            wd_d    = '0;
            bad_d   = bad_inc;
        end else begin
            if (bad_frame) begin
                bad_d = bad_inc;
            end
            if (timeout) begin
                state_d = LINK_DOWN;
                cmd_d   = SAFE_CMD;
                wd_d    = '0;
            end
        end
    end

    assign cmd_out_o   = cmd_q;
    assign cmd_valid_o = valid_q;
    assign link_ok_o   = (state_q == LINK_UP);
    assign fault_o     = (state_q == FAULT);

`ifdef CMD_DEC_STATS_EN
    logic        corr_frame;
    logic [15:0] corr_q;
    logic [15:0] drop_q;

    assign corr_frame = good_frame && (dec_status == SEC_CORR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_q <= 16'h0000;
            drop_q <= 16'h0000;
        end else begin
            if (corr_frame && corr_q != 16'hFFFF) begin
                corr_q <= corr_q + 16'd1;
            end
            if (bad_frame && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign corr_cnt_o = corr_q;
    assign drop_cnt_o = drop_q;
`else
    assign corr_cnt_o = 16'h0000;
    assign drop_cnt_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_decoder
// Description : Self-checking bench for uart_cmd_decoder. Frames are driven
//               from a vector table and hand-written sequences; expected
//               results are queued at drive time and compared two cycles
//               later when the decoder presents its result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

`ifdef CMD_DEC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        fault_clr;
    logic [3:0]  cmd_out;
    logic        cmd_valid;
    logic        link_ok;
    logic        fault;
    logic [15:0] corr_cnt;
    logic [15:0] drop_cnt;

    uart_cmd_decoder_if ifc ();

    uart_cmd_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (ifc),
        .fault_clr_i (fault_clr),
        .cmd_out_o   (cmd_out),
        .cmd_valid_o (cmd_valid),
        .link_ok_o   (link_ok),
        .fault_o     (fault),
        .corr_cnt_o  (corr_cnt),
        .drop_cnt_o  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       clr;
        logic       exp_valid;
        logic [3:0] exp_cmd;
        logic       exp_link;
        logic       exp_fault;
        logic       is_corr;
        logic       is_drop;
    } vec_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  cmd;
        logic        link;
        logic        fault;
        logic [15:0] corr;
        logic [15:0] drop;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   corr_m  = 0;
    int   drop_m  = 0;
    vec_t vecs[11];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic v, input logic [3:0] c, input logic l, input logic f);
        exp_t e;
        e.valid = v;
        e.cmd   = c;
        e.link  = l;
        e.fault = f;
        e.corr  = STATS ? 16'(corr_m) : 16'h0000;
        e.drop  = STATS ? 16'(drop_m) : 16'h0000;
        return e;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input exp_t e);
        ifc.rx_data    = d;
        ifc.rx_par_err = p;
        ifc.rx_done    = 1'b1;
        sbq.push_back(e);
        @(negedge clk);
        ifc.rx_done    = 1'b0;
        ifc.rx_par_err = 1'b0;
    endtask

    // Result of a frame appears two rising edges after its rx_done.
    logic p1, p2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
        end else begin
            p2 <= p1;
            p1 <= ifc.rx_done;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (p2) begin
                if (sbq.size() == 0) begin
                    chk("sb_empty_queue", 16'h1, 16'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_valid", {15'h0, cmd_valid}, {15'h0, e.valid});
                    chk("sb_cmd",   {12'h0, cmd_out},   {12'h0, e.cmd});
                    chk("sb_link",  {15'h0, link_ok},   {15'h0, e.link});
                    chk("sb_fault", {15'h0, fault},     {15'h0, e.fault});
                    chk("sb_corr",  corr_cnt,           e.corr);
                    chk("sb_drop",  drop_cnt,           e.drop);
                end
            end else if (cmd_valid) begin
                chk("stray_valid", 16'h1, 16'h0);
            end
        end
    end

    task automatic chk_reset_state(input string nm);
        chk({nm, "_cmd"},   {12'h0, cmd_out},   16'h0000);
        chk({nm, "_valid"}, {15'h0, cmd_valid}, 16'h0000);
        chk({nm, "_link"},  {15'h0, link_ok},   16'h0000);
        chk({nm, "_fault"}, {15'h0, fault},     16'h0000);
        chk({nm, "_corr"},  corr_cnt,           16'h0000);
        chk({nm, "_drop"},  drop_cnt,           16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //                data   par   clr   val   cmd    link  flt   corr  drop
        vecs[0]  = '{8'h55, 1'b0, 1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h45, 1'b0, 1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{8'hD5, 1'b0, 1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{8'h44, 1'b0, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{8'h33, 1'b0, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'h32, 1'b0, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{8'h55, 1'b1, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{8'h44, 1'b0, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{8'h44, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{8'h55, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{8'h55, 1'b0, 1'b1, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_n          = 1'b0;
        fault_clr      = 1'b0;
        ifc.rx_data    = 8'h00;
        ifc.rx_done    = 1'b0;
        ifc.rx_par_err = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table: frames back-to-back except where a fault clear is needed.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].clr) begin
                repeat (2) @(negedge clk);
                fault_clr = 1'b1;
                @(negedge clk);
                fault_clr = 1'b0;
            end
            if (vecs[i].is_corr) corr_m++;
            if (vecs[i].is_drop) drop_m++;
            send_frame(vecs[i].data, vecs[i].par,
                       mk_exp(vecs[i].exp_valid, vecs[i].exp_cmd, vecs[i].exp_link, vecs[i].exp_fault));
        end
        repeat (3) @(negedge clk);

        // fault_clr outside FAULT has no effect.
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        @(negedge clk);
        chk("clr_ignored_link",  {15'h0, link_ok}, 16'h1);
        chk("clr_ignored_fault", {15'h0, fault},   16'h0);

        // Watchdog: 287 idle cycles keep the link, the 288th drops it.
        send_frame(8'h33, 1'b0, mk_exp(1'b1, 4'h6, 1'b1, 1'b0));
        @(negedge clk);
        repeat (287) @(negedge clk);
        chk("wd_287_link", {15'h0, link_ok}, 16'h1);
        @(negedge clk);
        chk("wd_288_link", {15'h0, link_ok}, 16'h0);
        chk("wd_288_cmd",  {12'h0, cmd_out}, 16'h0);

        // Good frame landing on the timeout cycle keeps the link up.
        send_frame(8'h55, 1'b0, mk_exp(1'b1, 4'hB, 1'b1, 1'b0));
        @(negedge clk);
        repeat (286) @(negedge clk);
        send_frame(8'h33, 1'b0, mk_exp(1'b1, 4'h6, 1'b1, 1'b0));
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("wd_race_link", {15'h0, link_ok}, 16'h1);

        // Enter FAULT, then clear in the same cycle as a bad frame: bad count becomes 1.
        drop_m++;
        send_frame(8'h44, 1'b0, mk_exp(1'b0, 4'h6, 1'b1, 1'b0));
        drop_m++;
        send_frame(8'h44, 1'b0, mk_exp(1'b0, 4'h6, 1'b1, 1'b0));
        drop_m++;
        send_frame(8'h44, 1'b0, mk_exp(1'b0, 4'h0, 1'b0, 1'b1));
        repeat (2) @(negedge clk);
        drop_m++;
        send_frame(8'h44, 1'b0, mk_exp(1'b0, 4'h0, 1'b0, 1'b0));
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        drop_m++;
        send_frame(8'h44, 1'b0, mk_exp(1'b0, 4'h0, 1'b0, 1'b0));
        drop_m++;
        send_frame(8'h44, 1'b0, mk_exp(1'b0, 4'h0, 1'b0, 1'b1));
        repeat (3) @(negedge clk);

        // Reset while a frame sits in the pipeline: nothing emerges afterwards.
        ifc.rx_data = 8'h55;
        ifc.rx_done = 1'b1;
        @(negedge clk);
        ifc.rx_done = 1'b0;
        rst_n       = 1'b0;
        corr_m      = 0;
        drop_m      = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midreset_no_valid", {15'h0, cmd_valid}, 16'h0);
        end
        chk_reset_state("midreset");

        send_frame(8'h55, 1'b0, mk_exp(1'b1, 4'hB, 1'b1, 1'b0));
        repeat (3) @(negedge clk);
        chk("sb_drained", 16'(sbq.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
